lpe_column_collector: RTL
=========================

Name: lpe_column_collector

Overview:
- Sits at the bottom of each processing-array column, directly downstream of the last LinearProcessingElement's down output.
- Consumes the down stream, which carries forwarded operator-1 beats and PE results, and discards the operator beats.
- Packs the PE_NUMBER_J results of one batch into a single framed AXI stream: tlast on the final result, fixed tid/tdest.
- Feeds the column output interconnect.

Parameters:
- DATA_WIDTH, 16: width of result/operand data.
- PE_NUMBER_J, 4: results per batch, one per PE in the column.
- USER_WIDTH, 8: input tuser width.
- OP1_USER_MASK, 1<<(USER_WIDTH-2): tuser bit marking an operator-1 beat.
- RSLT_USER_MASK, 1<<(USER_WIDTH-1): tuser bit marking a result beat.
- ID_WIDTH, 8: m_axis_tid width.
- DEST_WIDTH, 8: m_axis_tdest width.
- OUTPUT_ID, 1: constant driven on m_axis_tid.
- OUTPUT_DEST, 1: constant driven on m_axis_tdest.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  down-stream data from the bottom PE.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input last.
- s_axis_tuser  in  USER_WIDTH  beat-type flags.
- m_axis_tdata  out  DATA_WIDTH  collected result.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  high on the PE_NUMBER_J-th result of a batch.
- m_axis_tid  out  ID_WIDTH  constant OUTPUT_ID.
- m_axis_tdest  out  DEST_WIDTH  constant OUTPUT_DEST.
- batch_done  out  1  one-cycle pulse when the last result of a batch is accepted at the input.
- err_user_flag  out  1  one-cycle pulse for an invalid beat.
- err_result_count  out  1  one-cycle pulse for a misaligned tlast (optional feature only; tied 0 otherwise).

Behaviour:
- Beat classification, on an accepted input beat:
  - op1 beat: OP1 bit set, RSLT bit clear.
  - result beat: RSLT bit set, OP1 bit clear.
  - invalid beat: both bits set, or neither.
- Acceptance rules:
  - op1 and invalid beats: s_axis_tready=1 unconditionally (sink); data discarded.
  - result beats: s_axis_tready = !buf_full; on handshake, write {data, last_flag} into the output buffer.
- Result counter rcnt, $clog2(PE_NUMBER_J) bits (min 1):
  - increments on each accepted result beat.
  - last_flag = (rcnt==PE_NUMBER_J-1).
  - on the last result, rcnt wraps to 0 and batch_done pulses on the next cycle.
- States:
  - IDLE: rcnt==0, no batch open. First accepted result -> COLLECT, or -> IDLE directly when PE_NUMBER_J==1.
  - COLLECT: partial batch. Last result -> IDLE.
  - ERR: entered on any invalid beat, from either state. Emits the err_user_flag pulse, holds s_axis_tready=0 for exactly one cycle, then -> IDLE with rcnt=0. Results already buffered remain and drain unchanged (the partial frame is emitted without tlast).
- Output buffer: 2-entry skid buffer.
  - Zero-bubble: 1 result/cycle sustained when m_axis_tready=1.
  - Latency input handshake -> m_axis_tvalid: 1 cycle.
  - m_axis_tdata/tlast registered, stable while tvalid && !tready.
- Simultaneous events:
  - Buffer full with an op1 beat presented: the op1 beat is still consumed.
  - Input write and output read in the same cycle: occupancy unchanged, no stall.
- Reset (rst low, asynchronous, any time including mid-batch):
  - state=IDLE, rcnt=0, buffer emptied.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
  - batch_done=0, err_user_flag=0, err_result_count=0.
  - s_axis_tready rises the first cycle after release.
- Output protocol: m_axis_tvalid never deasserts without a handshake.

Optional Feature:
- Macro: LPE_COLLECT_TLAST_CHECK_EN.
- Defined:
  - An accepted result beat whose s_axis_tlast != last_flag pulses err_result_count.
  - Buffers the beat with tlast forced 1.
  - Resets rcnt to 0 and enters IDLE, closing the frame early.
- Undefined: s_axis_tlast ignored; err_result_count tied 0; framing purely by count.

Decomposition:
- Package lpe_pkg:
  - OP1_USER_MASK and RSLT_USER_MASK defaults.
  - Collector FSM state encodings IDLE/COLLECT/ERR (2-bit).
  - Beat-type encoding (OP1/RSLT/INVALID), shared with the LinearProcessingElement control unit.
- Sub-module: lpe_axis_skid_buffer (2-entry, DATA_WIDTH+1 bits).

Test Plan:
- PE_NUMBER_J=4, results 0x11,0x22,0x33,0x44 interleaved with 3 op1 beats, m_axis_tready=1:
  - op1 beats dropped; output 0x11..0x44 on consecutive cycles.
  - tlast only on 0x44, tid=1, tdest=1, one batch_done.
- Same stream with m_axis_tready=0 for 5 cycles:
  - s_axis_tready falls after 2 results buffered; op1 beats still accepted.
  - no loss or duplication after release.
- 2 results, then tuser with both bits set:
  - err_user_flag pulse, one stall cycle.
  - 2 buffered results emitted without tlast; next 4 results form a full frame.
- Assert rst low mid-batch after 3 results (1 buffered):
  - m_axis_tvalid=0 immediately, asynchronously.
  - after release, a new 4-result batch frames correctly with tlast on the 4th.
- With LPE_COLLECT_TLAST_CHECK_EN, s_axis_tlast=1 on the 2nd result:
  - err_result_count pulse; output 2nd result with tlast=1.
  - next 4 results frame normally.
- Back-to-back batches, 8 results with no gaps, m_axis_tready=1:
  - 8 outputs in 8 consecutive cycles, tlast on the 4th and 8th.

Source files
------------

// File: rtl/lpe_pkg.sv
// Shared types for the LinearProcessingElement column: user-flag masks,
// beat classification and the column collector FSM encoding.
package lpe_pkg;

  localparam int unsigned LPE_USER_WIDTH_DEF     = 8;
  localparam int unsigned LPE_OP1_USER_MASK_DEF  = 1 << (LPE_USER_WIDTH_DEF - 2);
  localparam int unsigned LPE_RSLT_USER_MASK_DEF = 1 << (LPE_USER_WIDTH_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_ERR     = 2'd2
  } collect_state_e;

  typedef enum logic [1:0] {
    BEAT_OP1     = 2'd0,
    BEAT_RSLT    = 2'd1,
    BEAT_INVALID = 2'd2
  } beat_type_e;

  // Exactly one of the two flags must be set; anything else is malformed.
  function automatic beat_type_e classify_beat(input logic op1_hit, input logic rslt_hit);
    beat_type_e t;
    if (op1_hit && !rslt_hit)      t = BEAT_OP1;
    else if (rslt_hit && !op1_hit) t = BEAT_RSLT;
    else                           t = BEAT_INVALID;
    return t;
  endfunction

endpackage

// File: rtl/lpe_axis_skid_buffer.sv
// Two-entry registered skid buffer: one output register plus one skid register.
// Input ready depends only on local state, so no combinational ready path.
module lpe_axis_skid_buffer #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] skid_q;
  logic             skid_valid_q;
  logic             wr;
  logic             rd;

  // Full only when both registers hold data.
  assign in_ready  = !skid_valid_q;
  assign wr        = in_valid && in_ready;
  assign rd        = out_valid_q && out_ready;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || rd) begin
      // Output register is free this cycle: refill from skid first to keep order.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (wr) begin
        out_q       <= in_data;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (wr) begin
      skid_q       <= in_data;
      skid_valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/lpe_column_collector.sv
// Column collector: drops operator-1 beats, frames PE_NUMBER_J results per batch.
// Optional macro LPE_COLLECT_TLAST_CHECK_EN closes a frame early on a misaligned s_axis_tlast.
module lpe_column_collector
  import lpe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned PE_NUMBER_J    = 4,
  parameter int unsigned USER_WIDTH     = LPE_USER_WIDTH_DEF,
  parameter int unsigned OP1_USER_MASK  = 1 << (USER_WIDTH - 2),
  parameter int unsigned RSLT_USER_MASK = 1 << (USER_WIDTH - 1),
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned DEST_WIDTH     = 8,
  parameter int unsigned OUTPUT_ID      = 1,
  parameter int unsigned OUTPUT_DEST    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic                  batch_done,
  output logic                  err_user_flag,
  output logic                  err_result_count,
  output logic [1:0]            dbg_state
);

  // Both AXI-Stream ports: a beat transfers on a rising clk edge where valid && ready;
  // m_axis_tvalid/tdata/tlast never change while valid is high and ready is low.

  localparam int unsigned RCNT_W = (PE_NUMBER_J > 1) ? $clog2(PE_NUMBER_J) : 1;
  localparam logic [USER_WIDTH-1:0] OP1_M  = OP1_USER_MASK[USER_WIDTH-1:0];
  localparam logic [USER_WIDTH-1:0] RSLT_M = RSLT_USER_MASK[USER_WIDTH-1:0];
  localparam logic [RCNT_W-1:0]     RCNT_LAST = RCNT_W'(PE_NUMBER_J - 1);

  collect_state_e    state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              run_q;
  logic              batch_done_q;
  beat_type_e        beat_type;
  logic              rslt_acc;
  logic              inv_acc;
  logic              last_flag;
  logic              tlast_mis;
  logic              close_frame;
  logic              buf_in_ready;
  logic [DATA_WIDTH:0] buf_out;

  assign m_axis_tid    = ID_WIDTH'(OUTPUT_ID);
  assign m_axis_tdest  = DEST_WIDTH'(OUTPUT_DEST);
  assign m_axis_tdata  = buf_out[DATA_WIDTH:1];
  assign m_axis_tlast  = buf_out[0];
  assign dbg_state     = state_q;
  assign batch_done    = batch_done_q;
  assign err_user_flag = (state_q == ST_ERR);

  // Operator and malformed beats are always sunk; results wait for buffer space.
  always_comb begin
    beat_type     = classify_beat(|(s_axis_tuser & OP1_M), |(s_axis_tuser & RSLT_M));
    s_axis_tready = 1'b0;
    if (run_q && (state_q != ST_ERR))
      s_axis_tready = (beat_type == BEAT_RSLT) ? buf_in_ready : 1'b1;
  end

  assign rslt_acc  = s_axis_tvalid && s_axis_tready && (beat_type == BEAT_RSLT);
  assign inv_acc   = s_axis_tvalid && s_axis_tready && (beat_type == BEAT_INVALID);
  assign last_flag = (rcnt_q == RCNT_LAST);

`ifdef LPE_COLLECT_TLAST_CHECK_EN
  logic err_rc_q;

  assign tlast_mis        = rslt_acc && (s_axis_tlast != last_flag);
  assign err_result_count = err_rc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_rc_q <= 1'b0;
    else      err_rc_q <= tlast_mis;
  end
`else
  logic unused_tlast;

  assign unused_tlast     = s_axis_tlast;
  assign tlast_mis        = 1'b0;
  assign err_result_count = 1'b0;
`endif

  assign close_frame = last_flag || tlast_mis;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_ERR: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
      default: begin
        if (inv_acc) begin
          state_d = ST_ERR;
          rcnt_d  = '0;
        end else if (rslt_acc) begin
          if (close_frame) begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end else begin
            state_d = ST_COLLECT;
            rcnt_d  = rcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= '0;
      run_q        <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      run_q        <= 1'b1;
      batch_done_q <= rslt_acc && last_flag;
    end
  end

  lpe_axis_skid_buffer #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_axis_tdata, close_frame}),
    .in_valid  (rslt_acc),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule
